lisp_core: RTL and testbench



---
 rtl/lisp_core_pkg.sv | 49 ++++
 rtl/lisp_core_memory.sv | 20 ++
 rtl/lisp_core_seg7_driver.sv | 33 +++
 rtl/lisp_core.sv | 185 ++++++++++++++++++
 tb/tb_lisp_core.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/lisp_core_pkg.sv
// Shared definitions for the Lisp evaluator: heap tags, primitive codes,
// error codes, controller states and the seven-segment glyph table.
package lisp_defs;

  localparam logic [15:0] NIL = 16'h0000;

  localparam logic [14:0] TYPE_NUMBER    = 15'd0;
  localparam logic [14:0] TYPE_CONS      = 15'd1;
  localparam logic [14:0] TYPE_PRIMITIVE = 15'd2;

  localparam logic [15:0] PRIMOP_ADD = 16'd0;

  localparam logic [3:0] ERR_NONE           = 4'd0;
  localparam logic [3:0] ERR_BAD_TYPE       = 4'd1;
  localparam logic [3:0] ERR_NOT_APPLICABLE = 4'd2;
  localparam logic [3:0] ERR_BAD_ARG        = 4'd3;
  localparam logic [3:0] ERR_BAD_PRIMOP     = 4'd4;
  localparam logic [3:0] ERR_ADDR           = 4'd5;
  localparam logic [3:0] ERR_BAD_LIST       = 4'd6;

  typedef enum logic [3:0] {
    Idle, Fetch, Dispatch, ReadOp, CheckOp, ArgNext, ArgType, ArgVal, Halt, Error
  } state_e;

  // Active-low glyphs in {g,f,e,d,c,b,a} order for one hex digit.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/lisp_core_memory.sv
// Tagged heap storage with a single synchronous port (one-cycle read latency).
module memory #(
  parameter int MemorySize = 256
) (
  input  logic        clk,
  input  logic        we_i,
  input  logic [7:0]  addr_i,
  input  logic [15:0] wdata_i,
  output logic [15:0] rdata_o
);

  logic [15:0] memory [MemorySize];

  // One access per cycle; contents are never touched by reset.
  always_ff @(posedge clk) begin
    if (we_i) memory[addr_i] <= wdata_i;
    rdata_o <= memory[addr_i];
  end

endmodule

// File: rtl/lisp_core_seg7_driver.sv
// Multiplexed 4-digit hex display: free-running refresh counter picks the digit.
module seg7_driver
  import lisp_defs::*;
#(
  parameter int RefreshBits = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] value_i,
  output logic [7:0]  cathodes_o,
  output logic [3:0]  anodes_o
);

  logic [RefreshBits-1:0] refresh_q;
  logic [1:0]             sel;
  logic [3:0]             nibble;

  assign sel = refresh_q[RefreshBits-1 -: 2];

  // Refresh counter free-runs; cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) refresh_q <= '0;
    else      refresh_q <= refresh_q + 1'b1;
  end

  // Select the active digit and decode it; decimal point always dark.
  always_comb begin
    nibble     = value_i[4*sel +: 4];
    anodes_o   = ~(4'b0001 << sel);
    cathodes_o = {1'b1, hex_to_seg(nibble)};
  end

endmodule

// File: rtl/lisp_core.sv
// Lisp-subset evaluator: walks the tagged heap from a switch-selected pointer,
// evaluating numbers and (+ ...) applications, and shows result or error code.
module lisp_core
  import lisp_defs::*;
#(
  parameter int MemorySize  = 256,
  parameter int RefreshBits = 18
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_start,
  input  logic [15:0] switches,
  output logic [7:0]  cathodes,
  output logic [3:0]  anodes,
  output logic [15:0] leds
);

  typedef struct packed { state_e current; } state_reg_t;
  typedef struct packed { logic [15:0] current; } val_reg_t;

  state_reg_t  state;
  val_reg_t    val;
  state_e      state_d;
  logic [15:0] val_d;
  logic [3:0]  error_code_reg, err_d;
  logic        btn_prev_q, press;
  logic        is_cons_q, is_cons_d;
  logic [1:0]  phase_q, phase_d;
  logic [7:0]  expr_q, expr_d, node_q, node_d, car_q, car_d;
  logic [15:0] acc_q, acc_d;
  logic [7:0]  mem_addr, ptr8;
  logic [15:0] mem_rdata, disp;
  logic [14:0] rtag;
  logic        unused_sw;

  assign press     = btn_start & ~btn_prev_q;
  assign rtag      = mem_rdata[14:0];
  assign ptr8      = mem_rdata[7:0];
  assign unused_sw = ^switches[15:8];

  memory #(.MemorySize(MemorySize)) mem (
    .clk(clk), .we_i(1'b0), .addr_i(mem_addr), .wdata_i(16'h0000), .rdata_o(mem_rdata)
  );

  // State register; reset aborts any evaluation on the next edge.
  always_ff @(posedge clk) begin
    if (!rst) state.current <= Idle;
    else      state.current <= state_d;
  end

  // Next-state: each state consumes the word read in the previous cycle.
  always_comb begin
    state_d = state.current;
    unique case (state.current)
      Idle, Halt, Error: if (press) state_d = Fetch;
      Fetch:    state_d = (expr_q == 8'd0) ? Halt : (expr_q == 8'd1) ? Error : Dispatch;
      Dispatch: state_d = (rtag == TYPE_NUMBER || rtag == TYPE_CONS) ? ReadOp : Error;
      ReadOp:   state_d = !is_cons_q ? Halt : (ptr8 < 8'd2) ? Error : CheckOp;
      CheckOp:
        if (phase_q == 2'd0) state_d = (rtag == TYPE_PRIMITIVE) ? CheckOp : Error;
        else                 state_d = (mem_rdata == PRIMOP_ADD) ? ArgNext : Error;
      ArgNext:  state_d = (ptr8 == 8'd0) ? Halt : (ptr8 == 8'd1) ? Error : ArgType;
      ArgType:  state_d = (rtag == TYPE_CONS) ? ArgVal : Error;
      ArgVal:
        if (phase_q == 2'd0)      state_d = (ptr8 < 8'd2) ? Error : ArgVal;
        else if (phase_q == 2'd1) state_d = (rtag == TYPE_NUMBER) ? ArgVal : Error;
        else                      state_d = ArgNext;
      default:  state_d = Idle;
    endcase
  end

  // Datapath and heap addressing for each state.
  always_comb begin
    mem_addr  = expr_q;
    val_d     = val.current;
    err_d     = error_code_reg;
    expr_d    = expr_q;
    node_d    = node_q;
    car_d     = car_q;
    acc_d     = acc_q;
    phase_d   = phase_q;
    is_cons_d = is_cons_q;
    unique case (state.current)
      Idle, Halt, Error:
        if (press) begin
          expr_d  = switches[7:0];
          val_d   = NIL;
          err_d   = ERR_NONE;
          phase_d = 2'd0;
        end
      Fetch: begin
        mem_addr = expr_q;
        if (expr_q == 8'd1) err_d = ERR_ADDR;
      end
      Dispatch: begin
        mem_addr  = expr_q - 8'd1;
        is_cons_d = (rtag == TYPE_CONS);
        if (rtag != TYPE_NUMBER && rtag != TYPE_CONS) err_d = ERR_BAD_TYPE;
      end
      ReadOp: begin
        car_d    = ptr8;
        mem_addr = ptr8;
        phase_d  = 2'd0;
        if (!is_cons_q)         val_d = mem_rdata;
        else if (ptr8 == 8'd0)  err_d = ERR_NOT_APPLICABLE;
        else if (ptr8 == 8'd1)  err_d = ERR_ADDR;
      end
      CheckOp:
        if (phase_q == 2'd0) begin
          mem_addr = car_q - 8'd1;
          phase_d  = 2'd1;
          if (rtag != TYPE_PRIMITIVE) err_d = ERR_NOT_APPLICABLE;
        end else begin
          mem_addr = expr_q - 8'd2;
          phase_d  = 2'd0;
          acc_d    = 16'h0000;
          if (mem_rdata != PRIMOP_ADD) err_d = ERR_BAD_PRIMOP;
        end
      ArgNext: begin
        node_d   = ptr8;
        mem_addr = ptr8;
        if (ptr8 == 8'd0)      val_d = acc_q;
        else if (ptr8 == 8'd1) err_d = ERR_ADDR;
      end
      ArgType: begin
        mem_addr = node_q - 8'd1;
        phase_d  = 2'd0;
        if (rtag != TYPE_CONS) err_d = ERR_BAD_LIST;
      end
      ArgVal:
        if (phase_q == 2'd0) begin
          car_d    = ptr8;
          mem_addr = ptr8;
          phase_d  = 2'd1;
          if (ptr8 == 8'd0)      err_d = ERR_BAD_ARG;
          else if (ptr8 == 8'd1) err_d = ERR_ADDR;
        end else if (phase_q == 2'd1) begin
          mem_addr = car_q - 8'd1;
          phase_d  = 2'd2;
          if (rtag != TYPE_NUMBER) err_d = ERR_BAD_ARG;
        end else begin
          acc_d    = acc_q + mem_rdata;
          mem_addr = node_q - 8'd2;
          phase_d  = 2'd0;
        end
      default: ;
    endcase
  end

  // Control and result registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      val.current    <= NIL;
      error_code_reg <= ERR_NONE;
      btn_prev_q     <= 1'b0;
      phase_q        <= 2'd0;
      is_cons_q      <= 1'b0;
    end else begin
      val.current    <= val_d;
      error_code_reg <= err_d;
      btn_prev_q     <= btn_start;
      phase_q        <= phase_d;
      is_cons_q      <= is_cons_d;
    end
  end

  // Walk pointers and accumulator; always rewritten before use.
  always_ff @(posedge clk) begin
    expr_q <= expr_d;
    node_q <= node_d;
    car_q  <= car_d;
    acc_q  <= acc_d;
  end

  // Display word: error code banner in Error, otherwise the result.
  always_comb begin
    disp = (state.current == Error) ? (16'hEE00 | {12'h000, error_code_reg}) : val.current;
    leds = disp;
  end

  seg7_driver #(.RefreshBits(RefreshBits)) u_seg (
    .clk(clk), .rst(rst), .value_i(disp), .cathodes_o(cathodes), .anodes_o(anodes)
  );

endmodule

// File: tb/tb_lisp_core.sv
// Directed and randomized checks of lisp_core against a heap interpreter model.
module tb_lisp_core;
  import lisp_defs::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        btn_start = 1'b0;
  logic [15:0] switches = 16'h0000;
  logic [7:0]  cathodes;
  logic [3:0]  anodes;
  logic [15:0] leds;

  int ncmp = 0;
  int nfail = 0;

  logic [15:0] heap [256];
  logic [6:0]  segtab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  lisp_core #(.MemorySize(256), .RefreshBits(4)) dut (
    .clk(clk), .rst(rst), .btn_start(btn_start), .switches(switches),
    .cathodes(cathodes), .anodes(anodes), .leds(leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int tag_of(input int q);
    return int'(heap[q][14:0]);
  endfunction

  // Interpreter straight from the evaluation rules.
  function automatic void ref_eval(input int p, output logic [15:0] v, output logic [3:0] e);
    int car, lst, guard;
    logic [15:0] acc;
    v = 16'h0000; e = 4'd0;
    if (p == 0) return;
    if (p == 1) begin e = 4'd5; return; end
    if (tag_of(p) == 0) begin v = heap[p-1]; return; end
    if (tag_of(p) != 1) begin e = 4'd1; return; end
    car = int'(heap[p-1][7:0]);
    if (car == 0) begin e = 4'd2; return; end
    if (car == 1) begin e = 4'd5; return; end
    if (tag_of(car) != 2) begin e = 4'd2; return; end
    if (heap[car-1] != 16'h0000) begin e = 4'd4; return; end
    acc = 16'h0000;
    lst = int'(heap[p-2][7:0]);
    guard = 0;
    while (lst != 0 && guard < 300) begin
      guard++;
      if (lst == 1) begin e = 4'd5; return; end
      if (tag_of(lst) != 1) begin e = 4'd6; return; end
      car = int'(heap[lst-1][7:0]);
      if (car == 0) begin e = 4'd3; return; end
      if (car == 1) begin e = 4'd5; return; end
      if (tag_of(car) != 0) begin e = 4'd3; return; end
      acc = acc + heap[car-1];
      lst = int'(heap[lst-2][7:0]);
    end
    v = acc;
  endfunction

  task automatic clear_heap();
    for (int i = 0; i < 256; i++) heap[i] = 16'h0000;
  endtask

  task automatic put_num(input int p, input logic [15:0] v);
    heap[p] = 16'd0; heap[p-1] = v; heap[p-2] = 16'h0000;
  endtask

  task automatic put_cons(input int p, input int car, input int cdr);
    heap[p] = 16'd1; heap[p-1] = 16'(car); heap[p-2] = 16'(cdr);
  endtask

  task automatic put_prim(input int p, input logic [15:0] op);
    heap[p] = 16'd2; heap[p-1] = op;
  endtask

  task automatic load_heap();
    for (int i = 0; i < 256; i++) dut.mem.memory[i] = heap[i];
  endtask

  // Press start for one cycle, wait for a terminal state, compare with the model.
  task automatic run_expr(input string tag, input int p, input int lat_lim, output logic [15:0] exp_word);
    logic [15:0] ev;
    logic [3:0]  ee;
    int k;
    bit done;
    ref_eval(p, ev, ee);
    exp_word = (ee != 4'd0) ? (16'hEE00 | {12'h000, ee}) : ev;
    switches = 16'(p);
    btn_start = 1'b1;
    done = 1'b0;
    k = 0;
    while (!done && k < 200) begin
      @(posedge clk); #1;
      k++;
      btn_start = 1'b0;
      if (dut.state.current == Halt || dut.state.current == Error) done = 1'b1;
    end
    check({tag, ".done"}, 32'(done && k <= lat_lim), 32'd1);
    check({tag, ".state"}, 32'(dut.state.current), (ee != 4'd0) ? 32'(Error) : 32'(Halt));
    check({tag, ".err"}, 32'(dut.error_code_reg), 32'(ee));
    if (ee == 4'd0) check({tag, ".val"}, 32'(dut.val.current), 32'(ev));
    check({tag, ".leds"}, 32'(leds), 32'(exp_word));
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  seen;
    int d, n, kind, a, prim, expr;
    int nums[6];
    int nodes[6];

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst.state", 32'(dut.state.current), 32'(Idle));
    check("rst.val", 32'(dut.val.current), 32'h0);
    check("rst.err", 32'(dut.error_code_reg), 32'h0);
    check("rst.leds", 32'(leds), 32'h0);
    check("rst.anodes", 32'(anodes), 32'h0000000E);
    check("rst.cathodes", 32'(cathodes), 32'h000000C0);
    rst = 1'b1;
    @(posedge clk); #1;

    // Number.
    clear_heap();
    put_num(3, 16'hDEAD);
    load_heap();
    run_expr("num", 3, 4, w);
    check("num.leds_const", 32'(leds), 32'h0000DEAD);

    // NIL and bad address.
    run_expr("nil", 0, 200, w);
    run_expr("addr1", 1, 200, w);

    // (+ 5 3) and the error path with a number in function position.
    clear_heap();
    put_num(3, 16'd5); put_num(6, 16'd3);
    put_cons(9, 6, 0); put_cons(12, 3, 9);
    put_prim(18, 16'h0000); put_cons(15, 18, 12);
    load_heap();
    run_expr("add2", 15, 200, w);
    check("add2.val_const", 32'(dut.val.current), 32'h8);
    run_expr("notappl", 12, 200, w);
    check("notappl.leds_const", 32'(leds), 32'h0000EE02);

    // Overflow, then restart without reset on a different pointer.
    heap[2] = 16'hFFFF; heap[5] = 16'h0002;
    load_heap();
    run_expr("ovf", 15, 200, w);
    check("ovf.val_const", 32'(dut.val.current), 32'h1);
    run_expr("restart", 3, 4, w);

    // (+ 1 2 3 5) and the display multiplexing of its result.
    clear_heap();
    put_num(3, 16'd1); put_num(6, 16'd2); put_num(9, 16'd3); put_num(12, 16'd5);
    put_prim(15, 16'h0000);
    put_cons(18, 3, 21); put_cons(21, 6, 24); put_cons(24, 9, 27); put_cons(27, 12, 0);
    put_cons(30, 15, 18);
    load_heap();
    run_expr("add4", 30, 200, w);
    check("add4.val_const", 32'(dut.val.current), 32'hB);
    seen = 4'h0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      check("seg.onehot", 32'($countones(~anodes)), 32'd1);
      d = 0;
      for (int j = 0; j < 4; j++) if (!anodes[j]) d = j;
      seen[d] = 1'b1;
      check("seg.cathodes", 32'(cathodes), 32'({1'b1, segtab[w[4*d +: 4]]}));
    end
    check("seg.alldigits", 32'(seen), 32'hF);

    // Empty argument list and an unknown tag.
    put_cons(33, 15, 0);
    heap[36] = 16'd7;
    load_heap();
    run_expr("empty", 33, 200, w);
    run_expr("badtype", 36, 200, w);

    // Reset held mid-run aborts to Idle.
    switches = 16'd30;
    btn_start = 1'b1;
    @(posedge clk); #1;
    btn_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    check("midrst.state", 32'(dut.state.current), 32'(Idle));
    check("midrst.val", 32'(dut.val.current), 32'h0);
    rst = 1'b1;
    @(posedge clk); #1;
    run_expr("afterrst", 30, 200, w);

    // Randomized (+ ...) expressions with occasional injected faults.
    for (int it = 0; it < 12; it++) begin
      clear_heap();
      a = 3;
      n = $urandom_range(0, 5);
      kind = $urandom_range(0, 5);
      for (int i = 0; i < n; i++) begin
        nums[i] = a; put_num(a, 16'($urandom())); a += 3;
      end
      prim = a;
      put_prim(a, (kind == 3) ? 16'($urandom_range(1, 7)) : 16'h0000);
      a += 3;
      for (int i = 0; i < n; i++) begin nodes[i] = a; a += 3; end
      for (int i = 0; i < n; i++) put_cons(nodes[i], nums[i], (i == n - 1) ? 0 : nodes[i+1]);
      expr = a;
      put_cons(expr, prim, (n > 0) ? nodes[0] : 0);
      if (kind == 1) heap[expr-1] = 16'((n > 0) ? nums[0] : expr);
      if (kind == 2 && n > 0) heap[nodes[n-1]-1] = 16'(prim);
      if (kind == 4 && n > 0) heap[nodes[0]] = 16'd0;
      if (kind == 5) heap[expr] = 16'd7;
      load_heap();
      run_expr("rand", expr, 200, w);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
